fetch_stage: RTL and testbench

- Instruction-fetch stage of the RV32I five-stage pipeline; the producer side of the IF/ID interface that decode consumes.
- Owns the PC and issues word reads to instruction memory, one at a time.
- Delivers each fetched instruction with its pc/pc_next/valid into the IF/ID register.
- Handles downstream stall (hold buffer) and branch/jump redirect (squash plus discard of stale responses).

---
 rtl/fetch_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage, producer side of the IF/ID register.
// Owns the PC, keeps at most one instruction-memory read in flight, parks a
// response in a one-entry hold buffer while decode stalls, and squashes stale
// work on a branch/jump redirect.
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_squashed counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_en,
   input  logic [31:0] br_target,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_rmask,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_next,
   output logic [31:0] if_inst,
   output logic        if_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_squashed
`endif
);

   // ISSUE : nothing outstanding, pc is the next address to request
   // WAIT  : one request outstanding, pc is the address of that request
   // DROP  : one stale request outstanding, pc is the redirect target
   // HOLD  : hold buffer occupied, pc is the address after the buffered one
   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;

   // IF/ID register contents
   logic        ifid_valid_reg, ifid_valid_next;
   logic [31:0] ifid_pc_reg, ifid_pc_next;
   logic [31:0] ifid_npc_reg, ifid_npc_next;
   logic [31:0] ifid_inst_reg, ifid_inst_next;

   // Hold buffer; its occupancy is implied by being in ST_HOLD
   logic [31:0] buf_pc_reg, buf_pc_next;
   logic [31:0] buf_inst_reg, buf_inst_next;

   // Request generated this cycle (combinational toward memory)
   logic        req;
   logic [31:0] req_addr;

   logic [31:0] pc_plus4;
   assign pc_plus4 = pc_reg + 32'd4;

   // Next-state, PC, IF/ID, hold buffer and memory request decode
   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      ifid_valid_next = ifid_valid_reg;
      ifid_pc_next    = ifid_pc_reg;
      ifid_npc_next   = ifid_npc_reg;
      ifid_inst_next  = ifid_inst_reg;
      buf_pc_next     = buf_pc_reg;
      buf_inst_next   = buf_inst_reg;
      req             = 1'b0;
      req_addr        = pc_reg;

      case (state_reg)
         ST_ISSUE: begin
            if (br_en) begin
               pc_next         = br_target;
               ifid_valid_next = 1'b0;
            end else begin
               req        = 1'b1;
               state_next = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (br_en) begin
               // A response landing in the same cycle is simply dropped; if it
               // has not arrived yet it must be drained in ST_DROP.
               ifid_valid_next = 1'b0;
               pc_next         = br_target;
               state_next      = imem_resp ? ST_ISSUE : ST_DROP;
            end else if (imem_resp) begin
               if (stall) begin
                  buf_pc_next   = pc_reg;
                  buf_inst_next = imem_rdata;
                  pc_next       = pc_plus4;
                  state_next    = ST_HOLD;
               end else begin
                  ifid_valid_next = 1'b1;
                  ifid_pc_next    = pc_reg;
                  ifid_npc_next   = pc_plus4;
                  ifid_inst_next  = imem_rdata;
                  // Back-to-back request keeps one instruction per memory latency
                  req             = 1'b1;
                  req_addr        = pc_plus4;
                  pc_next         = pc_plus4;
               end
            end else if (!stall) begin
               ifid_valid_next = 1'b0;
            end
         end

         ST_DROP: begin
            ifid_valid_next = 1'b0;
            if (br_en) begin
               pc_next = br_target;
               // Stale response consumed by a newer redirect: nothing left in flight
               if (imem_resp) begin
                  state_next = ST_ISSUE;
               end
            end else if (imem_resp) begin
               req        = 1'b1;
               state_next = ST_WAIT;
            end
         end

         ST_HOLD: begin
            if (br_en) begin
               ifid_valid_next = 1'b0;
               pc_next         = br_target;
               state_next      = ST_ISSUE;
            end else if (!stall) begin
               ifid_valid_next = 1'b1;
               ifid_pc_next    = buf_pc_reg;
               ifid_npc_next   = buf_pc_reg + 32'd4;
               ifid_inst_next  = buf_inst_reg;
               req             = 1'b1;
               state_next      = ST_WAIT;
            end
         end

         default: begin
            state_next = ST_ISSUE;
         end
      endcase
   end

   // Memory request outputs; reset suppresses any request in the reset cycle
   assign imem_rmask = (req && !rst) ? 4'hF : 4'h0;
   assign imem_addr  = req_addr;

   // State, PC, IF/ID and hold buffer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_ISSUE;
         pc_reg         <= RESET_PC;
         ifid_valid_reg <= 1'b0;
         ifid_pc_reg    <= 32'h0;
         ifid_npc_reg   <= 32'h0;
         ifid_inst_reg  <= 32'h0;
         buf_pc_reg     <= 32'h0;
         buf_inst_reg   <= 32'h0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         ifid_valid_reg <= ifid_valid_next;
         ifid_pc_reg    <= ifid_pc_next;
         ifid_npc_reg   <= ifid_npc_next;
         ifid_inst_reg  <= ifid_inst_next;
         buf_pc_reg     <= buf_pc_next;
         buf_inst_reg   <= buf_inst_next;
      end
   end

   assign if_valid   = ifid_valid_reg;
   assign if_pc      = ifid_pc_reg;
   assign if_pc_next = ifid_npc_reg;
   assign if_inst    = ifid_inst_reg;

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_reg, squashed_reg;
   logic        fetch_inc;
   logic [1:0]  squash_inc;

   // Counter events: valid writes into IF/ID, and discarded work on redirect
   always_comb begin
      fetch_inc  = 1'b0;
      squash_inc = 2'd0;
      case (state_reg)
         ST_ISSUE: begin
            if (br_en) squash_inc = {1'b0, ifid_valid_reg};
         end
         ST_WAIT: begin
            if (br_en)
               squash_inc = {1'b0, ifid_valid_reg} + {1'b0, imem_resp};
            else if (imem_resp && !stall)
               fetch_inc = 1'b1;
         end
         ST_DROP: begin
            if (imem_resp) squash_inc = 2'd1;
         end
         ST_HOLD: begin
            if (br_en)
               squash_inc = 2'd1 + {1'b0, ifid_valid_reg};
            else if (!stall)
               fetch_inc = 1'b1;
         end
         default: begin
            fetch_inc = 1'b0;
         end
      endcase
   end

   // Free-running event counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         fetched_reg  <= 32'h0;
         squashed_reg <= 32'h0;
      end else begin
         fetched_reg  <= fetched_reg + {31'h0, fetch_inc};
         squashed_reg <= squashed_reg + {30'h0, squash_inc};
      end
   end

   assign perf_fetched  = fetched_reg;
   assign perf_squashed = squashed_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: two fetch_stage instances (default RESET_PC and a wrapping
// RESET_PC) driven by the same control stimulus, each with its own memory
// responder and a transaction-level reference model of the fetch stream.
module tb_fetch_stage;
   localparam logic [31:0] PC0 = 32'h1eceb000;
   localparam logic [31:0] PC1 = 32'hFFFFFFF8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, br_en;
   logic [31:0] br_target;
   logic [31:0] imem_addr [2];
   logic [3:0]  imem_rmask [2];
   logic [31:0] imem_rdata [2];
   logic        imem_resp [2];
   logic [31:0] if_pc [2];
   logic [31:0] if_pc_next [2];
   logic [31:0] if_inst [2];
   logic        if_valid [2];
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched [2];
   logic [31:0] perf_squashed [2];
`endif

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      fetch_stage #(.RESET_PC(gi == 0 ? PC0 : PC1)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .stall      (stall),
         .br_en      (br_en),
         .br_target  (br_target),
         .imem_addr  (imem_addr[gi]),
         .imem_rmask (imem_rmask[gi]),
         .imem_rdata (imem_rdata[gi]),
         .imem_resp  (imem_resp[gi]),
         .if_pc      (if_pc[gi]),
         .if_pc_next (if_pc_next[gi]),
         .if_inst    (if_inst[gi]),
         .if_valid   (if_valid[gi])
`ifdef FETCH_PERF_EN
         ,
         .perf_fetched  (perf_fetched[gi]),
         .perf_squashed (perf_squashed[gi])
`endif
      );
   end

   int tests = 0;
   int fails = 0;
   int lat_min = 1;
   int lat_max = 1;

   // Memory responder state
   bit          mem_pend [2];
   int          mem_cnt [2];
   logic [31:0] mem_data [2];

   // Reference model: next address to fetch, the in-flight fetch, the parked
   // entry and the expected IF/ID contents.
   logic [31:0] m_np [2];
   logic [31:0] m_opc [2];
   bit          m_ov [2];
   bit          m_st [2];
   bit          m_hv [2];
   logic [31:0] m_hpc [2];
   logic [31:0] m_hin [2];
   bit          m_v [2];
   logic [31:0] m_pc [2];
   logic [31:0] m_pn [2];
   logic [31:0] m_in [2];
   logic [31:0] m_fetched [2];
   logic [31:0] m_squashed [2];

   bit          exp_req [2];
   logic [31:0] exp_addr [2];
   logic [3:0]  obs_rmask [2];
   logic [31:0] obs_addr [2];

   // One clock cycle: present memory response, sample the combinational
   // request, advance through the edge, then update responder and model.
   task automatic step();
      bit          rsp_now [2];
      logic [31:0] dat_now [2];
      bit          dreq [2];
      bit          take;
      for (int k = 0; k < 2; k++) begin
         rsp_now[k] = mem_pend[k] && (mem_cnt[k] == 0);
         dat_now[k] = rsp_now[k] ? mem_data[k] : $urandom;
         imem_resp[k]  = rsp_now[k];
         imem_rdata[k] = dat_now[k];
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         obs_rmask[k] = imem_rmask[k];
         obs_addr[k]  = imem_addr[k];
         dreq[k]      = (imem_rmask[k] != 4'h0);
         exp_req[k]   = !rst && !br_en &&
                        ((!m_ov[k] && !m_hv[k]) ||
                         (m_ov[k] && rsp_now[k] && (m_st[k] || !stall)) ||
                         (m_hv[k] && !stall));
         exp_addr[k]  = m_np[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         // responder
         if (rsp_now[k]) mem_pend[k] = 1'b0;
         else if (mem_pend[k]) mem_cnt[k]--;
         if (dreq[k]) begin
            mem_pend[k] = 1'b1;
            mem_cnt[k]  = $urandom_range(lat_max, lat_min) - 1;
            mem_data[k] = $urandom;
         end
         if (rst) mem_pend[k] = 1'b0;
         // model
         if (rst) begin
            m_np[k] = (k == 0) ? PC0 : PC1;
            m_ov[k] = 0; m_st[k] = 0; m_hv[k] = 0; m_v[k] = 0;
            m_pc[k] = 0; m_pn[k] = 0; m_in[k] = 0;
            m_fetched[k] = 0; m_squashed[k] = 0;
         end else if (br_en) begin
            m_squashed[k] += 32'(m_v[k]) + 32'(m_hv[k]) + 32'(m_ov[k] && rsp_now[k]);
            m_np[k] = br_target;
            m_v[k]  = 0;
            m_hv[k] = 0;
            if (m_ov[k] && !rsp_now[k]) m_st[k] = 1;
            else m_ov[k] = 0;
         end else begin
            take = rsp_now[k] && m_ov[k];
            if (take) begin
               m_ov[k] = 0;
               if (m_st[k]) begin
                  m_v[k] = 0;
                  m_squashed[k]++;
               end else if (stall) begin
                  m_hv[k] = 1; m_hpc[k] = m_opc[k]; m_hin[k] = dat_now[k];
               end else begin
                  m_v[k] = 1; m_pc[k] = m_opc[k]; m_pn[k] = m_opc[k] + 4; m_in[k] = dat_now[k];
                  m_fetched[k]++;
               end
            end else if (m_ov[k] && (m_st[k] || !stall)) begin
               m_v[k] = 0;
            end else if (m_hv[k] && !stall) begin
               m_v[k] = 1; m_pc[k] = m_hpc[k]; m_pn[k] = m_hpc[k] + 4; m_in[k] = m_hin[k];
               m_hv[k] = 0;
               m_fetched[k]++;
            end
            if (exp_req[k]) begin
               m_ov[k] = 1; m_opc[k] = m_np[k]; m_st[k] = 0; m_np[k] = m_np[k] + 4;
            end
            if (k == 0 && m_v[0] && (take || m_fetched[0] != 0) && m_pc[0] == m_opc[0] - 4 && take && !stall && !m_st[0])
               $display("[TB] deliver #%0d pc=%h inst=%h", m_fetched[0], m_pc[0], m_in[0]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1; stall = 0; br_en = 0; br_target = 0; lat_min = 1; lat_max = 1;
      step();
      step();
      for (int k = 0; k < 2; k++) begin
         tests += 2;
         if (obs_rmask[k] !== 4'h0) begin
            fails++; $display("FAIL reset_rmask dut%0d: got %h, required 0", k, obs_rmask[k]);
         end
         if ({if_valid[k], if_pc[k], if_pc_next[k], if_inst[k]} !== 97'h0) begin
            fails++; $display("FAIL reset_ifid dut%0d: got v=%b pc=%h pn=%h inst=%h, required all 0",
                              k, if_valid[k], if_pc[k], if_pc_next[k], if_inst[k]);
         end
      end
      rst = 0;
   endtask

   // Latency 1 streaming, also covers the wrapping instance's first fetches
   task automatic test_latency1();
      logic [31:0] a [2][3];
      logic [31:0] e0 [3];
      logic [31:0] e1 [3];
      bit          r [2][3];
      e0 = '{32'h1eceb000, 32'h1eceb004, 32'h1eceb008};
      e1 = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
      for (int i = 0; i < 10; i++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            if (i < 3) begin a[k][i] = obs_addr[k]; r[k][i] = (obs_rmask[k] == 4'hF); end
            tests += 2;
            if (obs_rmask[k] !== (exp_req[k] ? 4'hF : 4'h0) || (exp_req[k] && obs_addr[k] !== exp_addr[k])) begin
               fails++; $display("FAIL lat1_req dut%0d cyc%0d: rmask=%h addr=%h, required req=%b addr=%h", k, i, obs_rmask[k], obs_addr[k], exp_req[k], exp_addr[k]);
            end
            if ({if_valid[k], if_pc[k], if_pc_next[k], if_inst[k]} !== {m_v[k], m_pc[k], m_pn[k], m_in[k]}) begin
               fails++; $display("FAIL lat1_ifid dut%0d cyc%0d: v=%b pc=%h pn=%h inst=%h, required v=%b pc=%h pn=%h inst=%h", k, i, if_valid[k], if_pc[k], if_pc_next[k], if_inst[k], m_v[k], m_pc[k], m_pn[k], m_in[k]);
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         tests += 2;
         if (!r[0][i] || a[0][i] !== e0[i]) begin
            fails++; $display("FAIL lat1_seq cyc%0d: req=%b addr=%h, required addr=%h", i, r[0][i], a[0][i], e0[i]);
         end
         if (!r[1][i] || a[1][i] !== e1[i]) begin
            fails++; $display("FAIL wrap_seq cyc%0d: req=%b addr=%h, required addr=%h", i, r[1][i], a[1][i], e1[i]);
         end
      end
   endtask

   task automatic test_latency3();
      int nreq = 0;
      int nval = 0;
      rst = 1; step(); rst = 0;
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 13; i++) begin
         step();
         if (obs_rmask[0] == 4'hF) nreq++;
         if (if_valid[0]) nval++;
         for (int k = 0; k < 2; k++) begin
            tests += 2;
            if (obs_rmask[k] !== (exp_req[k] ? 4'hF : 4'h0) || (exp_req[k] && obs_addr[k] !== exp_addr[k])) begin
               fails++; $display("FAIL lat3_req dut%0d cyc%0d: rmask=%h addr=%h, required req=%b addr=%h", k, i, obs_rmask[k], obs_addr[k], exp_req[k], exp_addr[k]);
            end
            if ({if_valid[k], if_pc[k], if_pc_next[k], if_inst[k]} !== {m_v[k], m_pc[k], m_pn[k], m_in[k]}) begin
               fails++; $display("FAIL lat3_ifid dut%0d cyc%0d: v=%b pc=%h inst=%h, required v=%b pc=%h inst=%h", k, i, if_valid[k], if_pc[k], if_inst[k], m_v[k], m_pc[k], m_in[k]);
            end
         end
      end
      // requests at cycles 0,3,6,9,12; deliveries visible after cycles 3,6,9,12
      tests += 2;
      if (nreq != 5) begin fails++; $display("FAIL lat3_reqcount: got %0d, required 5", nreq); end
      if (nval != 4) begin fails++; $display("FAIL lat3_validcount: got %0d, required 4", nval); end
   endtask

   task automatic test_hold();
      rst = 1; step(); rst = 0;
      lat_min = 1; lat_max = 1;
      step();           // request 1eceb000
      step();           // deliver 1eceb000, request 1eceb004
      stall = 1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) stall = 0;
         step();
         tests += 2;
         if (i < 4 && (obs_rmask[0] !== 4'h0 || if_pc[0] !== PC0 || if_valid[0] !== 1'b1)) begin
            fails++; $display("FAIL hold_keep cyc%0d: rmask=%h v=%b pc=%h, required rmask=0 v=1 pc=%h", i, obs_rmask[0], if_valid[0], if_pc[0], PC0);
         end
         if (i == 4 && (obs_rmask[0] !== 4'hF || obs_addr[0] !== 32'h1eceb008 || if_pc[0] !== 32'h1eceb004 || if_valid[0] !== 1'b1)) begin
            fails++; $display("FAIL hold_release: rmask=%h addr=%h v=%b pc=%h, required F 1eceb008 1 1eceb004", obs_rmask[0], obs_addr[0], if_valid[0], if_pc[0]);
         end
         if ({if_valid[0], if_pc[0], if_pc_next[0], if_inst[0]} !== {m_v[0], m_pc[0], m_pn[0], m_in[0]}) begin
            fails++; $display("FAIL hold_ifid cyc%0d: pc=%h inst=%h, required pc=%h inst=%h", i, if_pc[0], if_inst[0], m_pc[0], m_in[0]);
         end
      end
   endtask

   task automatic test_redirect();
      bit          seen = 0;
      bit          stale = 0;
      logic [31:0] first = 0;
      logic [31:0] sq0 = 0;
      rst = 1; step(); rst = 0;
      lat_min = 3; lat_max = 3;
      step();           // request 1eceb000
      step();           // waiting
`ifdef FETCH_PERF_EN
      sq0 = perf_squashed[0];
`endif
      br_en = 1; br_target = 32'h1eceb100;
      step();
      br_en = 0;
      tests++;
      if (if_valid[0] !== 1'b0) begin fails++; $display("FAIL redir_bubble: v=%b, required 0", if_valid[0]); end
      for (int i = 0; i < 8; i++) begin
         step();
         if (!seen && obs_rmask[0] == 4'hF) begin seen = 1; first = obs_addr[0]; end
         if (if_valid[0] && if_pc[0] == PC0) stale = 1;
         tests++;
         if ({if_valid[0], if_pc[0], if_inst[0]} !== {m_v[0], m_pc[0], m_in[0]}) begin
            fails++; $display("FAIL redir_ifid cyc%0d: v=%b pc=%h, required v=%b pc=%h", i, if_valid[0], if_pc[0], m_v[0], m_pc[0]);
         end
      end
      tests += 2;
      if (!seen || first !== 32'h1eceb100) begin fails++; $display("FAIL redir_target: seen=%b addr=%h, required 1eceb100", seen, first); end
      if (stale) begin fails++; $display("FAIL redir_stale: stale 1eceb000 delivered, required discard"); end
`ifdef FETCH_PERF_EN
      tests++;
      if (perf_squashed[0] - sq0 !== 32'd1) begin fails++; $display("FAIL redir_perf: delta=%0d, required 1", perf_squashed[0] - sq0); end
`endif
      if (sq0 != 0) sq0 = 0;
   endtask

   task automatic test_br_priority();
      bit leaked = 0;
      rst = 1; step(); rst = 0;
      lat_min = 1; lat_max = 1;
      step(); step();
      stall = 1;
      step();           // 1eceb004 parked in the hold buffer
      step();
      br_en = 1; br_target = 32'h1eceb200;
      step();
      br_en = 0;
      tests += 2;
      if (obs_rmask[0] !== 4'h0) begin fails++; $display("FAIL prio_noreq: rmask=%h, required 0", obs_rmask[0]); end
      if (if_valid[0] !== 1'b0) begin fails++; $display("FAIL prio_valid: v=%b, required 0", if_valid[0]); end
      step();
      tests++;
      if (obs_rmask[0] !== 4'hF || obs_addr[0] !== 32'h1eceb200) begin
         fails++; $display("FAIL prio_target: rmask=%h addr=%h, required F 1eceb200", obs_rmask[0], obs_addr[0]);
      end
      stall = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (if_valid[0] && if_pc[0] == 32'h1eceb004) leaked = 1;
      end
      tests++;
      if (leaked) begin fails++; $display("FAIL prio_buffer: cleared entry 1eceb004 delivered, required discard"); end
   endtask

   task automatic test_reset_midop();
      rst = 1; step(); rst = 0;
      lat_min = 3; lat_max = 3;
      step(); step();
      rst = 1; step(); rst = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (i == 0 && (obs_rmask[0] !== 4'hF || obs_addr[0] !== PC0)) begin
            fails++; $display("FAIL midrst_req: rmask=%h addr=%h, required F %h", obs_rmask[0], obs_addr[0], PC0);
         end
         if (i < 3 && if_valid[0] !== 1'b0) begin
            fails++; $display("FAIL midrst_valid cyc%0d: v=%b, required 0", i, if_valid[0]);
         end
         if (i == 3 && (if_valid[0] !== 1'b1 || if_pc[0] !== PC0)) begin
            fails++; $display("FAIL midrst_first: v=%b pc=%h, required 1 %h", if_valid[0], if_pc[0], PC0);
         end
      end
   endtask

   task automatic test_random();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 1500; i++) begin
         stall = ($urandom_range(9, 0) < 3);
         br_en = ($urandom_range(99, 0) < 6);
         br_target = ($urandom_range(3, 0) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFFFFFC);
         rst = ($urandom_range(299, 0) == 0);
         step();
         for (int k = 0; k < 2; k++) begin
            tests += 2;
            if (obs_rmask[k] !== (exp_req[k] ? 4'hF : 4'h0) || (exp_req[k] && obs_addr[k] !== exp_addr[k])) begin
               fails++; $display("FAIL rand_req dut%0d cyc%0d: rmask=%h addr=%h, required req=%b addr=%h", k, i, obs_rmask[k], obs_addr[k], exp_req[k], exp_addr[k]);
            end
            if ({if_valid[k], if_pc[k], if_pc_next[k], if_inst[k]} !== {m_v[k], m_pc[k], m_pn[k], m_in[k]}) begin
               fails++; $display("FAIL rand_ifid dut%0d cyc%0d: v=%b pc=%h pn=%h inst=%h, required v=%b pc=%h pn=%h inst=%h", k, i, if_valid[k], if_pc[k], if_pc_next[k], if_inst[k], m_v[k], m_pc[k], m_pn[k], m_in[k]);
            end
`ifdef FETCH_PERF_EN
            tests++;
            if ({perf_fetched[k], perf_squashed[k]} !== {m_fetched[k], m_squashed[k]}) begin
               fails++; $display("FAIL rand_perf dut%0d cyc%0d: fetched=%0d squashed=%0d, required %0d %0d", k, i, perf_fetched[k], perf_squashed[k], m_fetched[k], m_squashed[k]);
            end
`endif
         end
      end
      rst = 0; stall = 0; br_en = 0;
   endtask

   initial begin
      rst = 1; stall = 0; br_en = 0; br_target = 0;
      imem_resp[0] = 0; imem_resp[1] = 0; imem_rdata[0] = 0; imem_rdata[1] = 0;
      test_reset();
      test_latency1();
      test_latency3();
      test_hold();
      stall = 0;
      test_redirect();
      test_br_priority();
      stall = 0;
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
